// File: rtl/axi_lite_slave_regs_if.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_regs_if
// AXI4-Lite bus bundle between the example master and the register bank.
//   AW channel : awaddr, awprot, awvalid (master -> slave), awready (slave -> master)
//   W  channel : wdata, wstrb, wvalid (master -> slave), wready (slave -> master)
//   B  channel : bresp, bvalid (slave -> master), bready (master -> slave)
//   AR channel : araddr, arprot, arvalid (master -> slave), arready (slave -> master)
//   R  channel : rdata, rresp, rvalid (slave -> master), rready (master -> slave)
// -----------------------------------------------------------------------------
interface axi_lite_slave_regs_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [AXI_ADDR_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        arvalid;
   logic                        arready;
   logic [AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid,    input wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input  bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input  rready
   );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite slave holding NUM_REGS 32-bit registers starting at BASE_ADDR.
// The last register is a read-only ID word (REG_ID); register 0 is exported
// as a live control word. Responses: OKAY for a normal access, SLVERR for a
// write to the ID word, DECERR for an address outside the bank.
// Ports:
//   aclk    : clock, rising edge
//   aresetn : asynchronous active-low reset
//   s_axi   : AXI4-Lite slave modport (AW/W/B/AR/R channels, prot ignored)
//   ctrl_o  : current value of register 0
// Only a 32-bit data bus is supported.
// -----------------------------------------------------------------------------
module axi_lite_slave_regs #(
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        NUM_REGS       = 8,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_1000,
   parameter logic [AXI_DATA_WIDTH-1:0] REG_ID         = 32'h5A5A_0001
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   axi_lite_slave_regs_if.slave      s_axi,
   output logic [AXI_DATA_WIDTH-1:0] ctrl_o
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam logic [AXI_ADDR_WIDTH-1:0] SPAN   = AXI_ADDR_WIDTH'(NUM_REGS * 4);
   localparam logic [IDX_W-1:0]          ID_IDX = IDX_W'(NUM_REGS - 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_e;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   // Writable storage only; the ID word is a constant and has no flop.
   logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS-1];

   // Halves of a split write, held until the other half arrives.
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]         wstrb_q;
   logic [1:0]                bresp_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   logic                      aw_ready, w_ready, b_valid, ar_ready, r_valid;
   logic                      aw_latch, w_latch, wr_commit, ar_hs;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_offset, rd_offset;
   logic [AXI_DATA_WIDTH-1:0] wr_data, rd_word;
   logic [STRB_W-1:0]         wr_strb;
   logic                      wr_hit, rd_hit, wr_we;
   logic [IDX_W-1:0]          wr_idx, rd_idx;
   logic [1:0]                wr_resp;

   // ---------------------------------------------------------------- decode
   // The addr >= BASE_ADDR term rejects addresses that wrap below the base.
   assign wr_offset = wr_addr - BASE_ADDR;
   assign wr_hit    = (wr_addr >= BASE_ADDR) && (wr_offset < SPAN);
   assign wr_idx    = wr_offset[IDX_W+1:2];
   assign wr_resp   = !wr_hit ? RESP_DECERR : ((wr_idx == ID_IDX) ? RESP_SLVERR : RESP_OKAY);
   assign wr_we     = wr_commit && wr_hit && (wr_idx != ID_IDX);

   assign rd_offset = s_axi.araddr - BASE_ADDR;
   assign rd_hit    = (s_axi.araddr >= BASE_ADDR) && (rd_offset < SPAN);
   assign rd_idx    = rd_offset[IDX_W+1:2];

   // ------------------------------------------------------------- write FSM
   always_comb begin
      wr_state_d = wr_state_q;
      aw_ready   = 1'b0;
      w_ready    = 1'b0;
      b_valid    = 1'b0;
      aw_latch   = 1'b0;
      w_latch    = 1'b0;
      wr_commit  = 1'b0;
      wr_addr    = s_axi.awaddr;
      wr_data    = s_axi.wdata;
      wr_strb    = s_axi.wstrb;
      case (wr_state_q)
         WR_IDLE: begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            if (s_axi.awvalid && s_axi.wvalid) begin
               wr_commit  = 1'b1;
               wr_state_d = WR_RESP;
            end else if (s_axi.awvalid) begin
               aw_latch   = 1'b1;
               wr_state_d = WR_WAIT_W;
            end else if (s_axi.wvalid) begin
               w_latch    = 1'b1;
               wr_state_d = WR_WAIT_AW;
            end
         end
         WR_WAIT_W: begin
            w_ready = 1'b1;
            wr_addr = awaddr_q;
            if (s_axi.wvalid) begin
               wr_commit  = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_WAIT_AW: begin
            aw_ready = 1'b1;
            wr_data  = wdata_q;
            wr_strb  = wstrb_q;
            if (s_axi.awvalid) begin
               wr_commit  = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            b_valid = 1'b1;
            if (s_axi.bready) begin
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q <= WR_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         if (aw_latch) begin
            awaddr_q <= s_axi.awaddr;
         end
         if (w_latch) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
         end
         if (wr_commit) begin
            bresp_q <= wr_resp;
         end
      end
   end

   // --------------------------------------------------------- register file
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_we) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) begin
                     regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // -------------------------------------------------------------- read FSM
   // Read data is captured from regs_q before this edge's write lands, so a
   // read and a write to the same register on one edge returns the old value.
   always_comb begin
      rd_word = REG_ID;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_word = regs_q[i];
         end
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      ar_ready   = 1'b0;
      r_valid    = 1'b0;
      ar_hs      = 1'b0;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: begin
            ar_ready = 1'b1;
            if (s_axi.arvalid) begin
               ar_hs      = 1'b1;
               rdata_d    = rd_hit ? rd_word : '0;
               rresp_d    = rd_hit ? RESP_OKAY : RESP_DECERR;
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            r_valid = 1'b1;
            if (s_axi.rready) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state_q <= RD_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         if (ar_hs) begin
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
         end
      end
   end

   // --------------------------------------------------------------- outputs
   assign s_axi.awready = aw_ready;
   assign s_axi.wready  = w_ready;
   assign s_axi.bvalid  = b_valid;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = ar_ready;
   assign s_axi.rvalid  = r_valid;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign ctrl_o        = regs_q[0];

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_slave_regs
// Directed scenarios plus randomized traffic against a behavioural model of
// the register bank (array of words, address -> index by arithmetic). A
// negedge monitor compares ctrl_o, bresp and rdata/rresp with the model.
// -----------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] ID   = 32'h5A5A_0001;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] ctrl;

   always #5 aclk = ~aclk;

   axi_lite_slave_regs_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

   axi_lite_slave_regs #(
      .AXI_DATA_WIDTH(32),
      .AXI_ADDR_WIDTH(32),
      .NUM_REGS      (8),
      .BASE_ADDR     (32'h0000_1000),
      .REG_ID        (32'h5A5A_0001)
   ) dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .s_axi  (bus),
      .ctrl_o (ctrl)
   );

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   logic [31:0] model [8];
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (no handshake within budget)", name);
   endtask

   // ------------------------------------------------------------ model
   function automatic bit in_bank(input logic [31:0] addr);
      return (addr >= BASE) && (addr < BASE + 32'd32);
   endfunction

   function automatic int idx_of(input logic [31:0] addr);
      return int'((addr - BASE) / 4);
   endfunction

   function automatic logic [1:0] model_wresp(input logic [31:0] addr);
      if (!in_bank(addr)) return 2'b11;
      if (idx_of(addr) == 7) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [33:0] model_read(input logic [31:0] addr);
      if (!in_bank(addr)) return {2'b11, 32'h0};
      if (idx_of(addr) == 7) return {2'b00, ID};
      return {2'b00, model[idx_of(addr)]};
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic [31:0] w;
      if (model_wresp(addr) != 2'b00) return;
      w = model[idx_of(addr)];
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      end
      model[idx_of(addr)] = w;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model[i] = 32'h0;
      exp_b.delete();
      exp_r.delete();
   endtask

   // ------------------------------------------------------------ monitor
   always @(negedge aclk) begin
      if (mon_en && aresetn) begin
         chk("ctrl_o", ctrl, model[0]);
         if (bus.bvalid) begin
            if (exp_b.size() == 0) begin
               chk("bvalid_unexpected", 32'(bus.bvalid), 32'h0);
            end else begin
               chk("bresp", 32'(bus.bresp), 32'(exp_b[0]));
               if (bus.bready) void'(exp_b.pop_front());
            end
         end
         if (bus.rvalid) begin
            if (exp_r.size() == 0) begin
               chk("rvalid_unexpected", 32'(bus.rvalid), 32'h0);
            end else begin
               chk("rdata", bus.rdata, exp_r[0][31:0]);
               chk("rresp", 32'(bus.rresp), 32'(exp_r[0][33:32]));
               if (bus.rready) void'(exp_r.pop_front());
            end
         end
      end
   end

   // ------------------------------------------------------------ drivers
   // lead > 0: W is presented lead cycles before AW; lead < 0: AW first.
   // Tasks start and end one time unit after a rising edge.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bdly, output logic [1:0] resp);
      bit aw_pend = 1'b1;
      bit w_pend  = 1'b1;
      bit done    = 1'b0;
      bit hs_aw, hs_w, commit;
      int cyc     = 0;
      int aw_start = (lead > 0) ? lead : 0;
      int w_start  = (lead < 0) ? -lead : 0;
      resp = 2'bxx;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!done && cyc < 40) begin
         bus.awvalid = aw_pend && (cyc >= aw_start);
         bus.wvalid  = w_pend && (cyc >= w_start);
         @(negedge aclk);
         if (!w_pend && aw_pend) chk("wready_while_waiting", 32'(bus.wready), 32'h0);
         if (!aw_pend && w_pend) chk("awready_while_waiting", 32'(bus.awready), 32'h0);
         hs_aw  = bus.awvalid && bus.awready;
         hs_w   = bus.wvalid && bus.wready;
         commit = (hs_aw || hs_w) && (hs_aw || !aw_pend) && (hs_w || !w_pend);
         if (commit) exp_b.push_back(model_wresp(addr));
         @(posedge aclk);
         #1;
         if (hs_aw) begin aw_pend = 1'b0; bus.awvalid = 1'b0; end
         if (hs_w)  begin w_pend  = 1'b0; bus.wvalid  = 1'b0; end
         if (commit) begin model_write(addr, data, strb); done = 1'b1; end
         cyc++;
      end
      if (!done) begin
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b0;
         fail_now("write_handshake_timeout");
         return;
      end
      for (int k = 0; k < bdly; k++) begin
         @(negedge aclk);
         chk("bvalid_held", 32'(bus.bvalid), 32'h1);
         @(posedge aclk);
         #1;
      end
      bus.bready = 1'b1;
      @(negedge aclk);
      chk("bvalid_present", 32'(bus.bvalid), 32'h1);
      resp = bus.bresp;
      @(posedge aclk);
      #1;
      bus.bready = 1'b0;
      @(negedge aclk);
      chk("bvalid_dropped", 32'(bus.bvalid), 32'h0);
      chk("wr_ready_restored", {30'h0, bus.awready, bus.wready}, 32'h3);
      @(posedge aclk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp);
      bit done = 1'b0;
      int cyc  = 0;
      data = 'x;
      resp = 'x;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      while (!done && cyc < 40) begin
         @(negedge aclk);
         if (bus.arready) begin
            exp_r.push_back(model_read(addr));
            done = 1'b1;
         end
         @(posedge aclk);
         #1;
         cyc++;
      end
      bus.arvalid = 1'b0;
      if (!done) begin
         fail_now("read_handshake_timeout");
         return;
      end
      for (int k = 0; k < rdly; k++) begin
         @(negedge aclk);
         chk("rvalid_held", 32'(bus.rvalid), 32'h1);
         @(posedge aclk);
         #1;
      end
      bus.rready = 1'b1;
      @(negedge aclk);
      chk("rvalid_present", 32'(bus.rvalid), 32'h1);
      data = bus.rdata;
      resp = bus.rresp;
      @(posedge aclk);
      #1;
      bus.rready = 1'b0;
      @(negedge aclk);
      chk("rvalid_dropped", 32'(bus.rvalid), 32'h0);
      chk("arready_restored", 32'(bus.arready), 32'h1);
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int sel = int'($urandom_range(0, 11));
      if (sel < 8) return BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
      case (sel)
         8:       return 32'h0000_2000;
         9:       return 32'h0000_0FFC;
         10:      return 32'h0000_1020;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // ------------------------------------------------------------ stimulus
   logic [1:0]  wresp, rresp;
   logic [31:0] rdata, rdata2;
   logic [1:0]  rresp2;

   initial begin
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      model_clear();

      // Reset state
      #1;
      chk("rst_ready", {29'h0, bus.awready, bus.wready, bus.arready}, 32'h7);
      chk("rst_valid", {30'h0, bus.bvalid, bus.rvalid}, 32'h0);
      chk("rst_resp", {28'h0, bus.bresp, bus.rresp}, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_ctrl", ctrl, 32'h0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      mon_en = 1'b1;

      // AW and W together
      do_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, wresp);
      chk("t1_bresp", 32'(wresp), 32'h0);
      chk("t1_ctrl", ctrl, 32'hDEADBEEF);
      do_read(32'h1000, 0, rdata, rresp);
      chk("t1_rdata", rdata, 32'hDEADBEEF);
      chk("t1_rresp", 32'(rresp), 32'h0);

      // W three cycles ahead of AW, bready held low for 5 cycles
      do_write(32'h1004, 32'hCAFEBABE, 4'hF, 3, 5, wresp);
      chk("t2_bresp", 32'(wresp), 32'h0);
      do_read(32'h1004, 2, rdata, rresp);
      chk("t2_rdata", rdata, 32'hCAFEBABE);

      // Byte strobes
      do_write(32'h1008, 32'h12345678, 4'hF, -2, 0, wresp);
      do_write(32'h1008, 32'hFFFFFFFF, 4'b0101, 0, 1, wresp);
      do_read(32'h1008, 0, rdata, rresp);
      chk("t3_rdata", rdata, 32'h12FF56FF);

      // Out of range
      do_write(32'h2000, 32'h9ABCDEF0, 4'hF, 0, 0, wresp);
      chk("t4_bresp", 32'(wresp), 32'h3);
      do_read(32'h2000, 0, rdata, rresp);
      chk("t4_rdata", rdata, 32'h0);
      chk("t4_rresp", 32'(rresp), 32'h3);

      // ID register
      do_write(32'h101C, 32'h5555AAAA, 4'hF, 0, 0, wresp);
      chk("t5_bresp", 32'(wresp), 32'h2);
      do_read(32'h101C, 0, rdata, rresp);
      chk("t5_rdata", rdata, 32'h5A5A0001);
      chk("t5_rresp", 32'(rresp), 32'h0);

      // Read and write commit to the same register on the same edge
      fork
         do_write(32'h1000, 32'h11111111, 4'hF, 0, 0, wresp);
         do_read(32'h1000, 0, rdata, rresp);
      join
      chk("t6_old_value", rdata, 32'hDEADBEEF);
      do_read(32'h1000, 0, rdata, rresp);
      chk("t6_new_value", rdata, 32'h11111111);

      // Randomized traffic, checked by the monitor against the model
      for (int n = 0; n < 60; n++) begin
         int mode = int'($urandom_range(0, 2));
         logic [31:0] wa = rand_addr();
         logic [31:0] ra = rand_addr();
         logic [31:0] wd = $urandom();
         logic [3:0]  ws = 4'($urandom_range(0, 15));
         int lead = int'($urandom_range(0, 6)) - 3;
         int bd   = int'($urandom_range(0, 3));
         int rd   = int'($urandom_range(0, 3));
         if (mode == 0) begin
            do_write(wa, wd, ws, lead, bd, wresp);
         end else if (mode == 1) begin
            do_read(ra, rd, rdata, rresp);
         end else begin
            fork
               do_write(wa, wd, ws, lead, bd, wresp);
               do_read(ra, rd, rdata2, rresp2);
            join
         end
      end
      for (int i = 0; i < 8; i++) begin
         do_read(BASE + 32'(4 * i), 0, rdata, rresp);
      end

      // Reset asserted while the write response is pending
      bus.awaddr  = 32'h1004;
      bus.wdata   = 32'h00000077;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      exp_b.push_back(2'b00);
      @(posedge aclk);
      #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      model_write(32'h1004, 32'h00000077, 4'hF);
      @(negedge aclk);
      chk("t7_bvalid_before_reset", 32'(bus.bvalid), 32'h1);
      #2;
      aresetn = 1'b0;
      model_clear();
      #1;
      chk("t7_bvalid_async_drop", 32'(bus.bvalid), 32'h0);
      chk("t7_ready_async", {29'h0, bus.awready, bus.wready, bus.arready}, 32'h7);
      chk("t7_ctrl_cleared", ctrl, 32'h0);
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      #2;
      aresetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge aclk);
         chk("t7_no_response_after_reset", {30'h0, bus.bvalid, bus.rvalid}, 32'h0);
      end
      @(posedge aclk);
      #1;
      do_read(32'h1004, 0, rdata, rresp);
      chk("t7_reg1_cleared", rdata, 32'h0);
      do_read(32'h1000, 0, rdata, rresp);
      chk("t7_reg0_cleared", rdata, 32'h0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite slave register bank that terminates the transactions issued by the AXI-Lite example master.
- Provides NUM_REGS 32-bit registers at BASE_ADDR. The last register is a read-only ID word.
- Returns OKAY, SLVERR or DECERR so that every master response path can be exercised.
- Register 0 is exported as a control word for downstream logic.

Parameters:
- AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- AXI_ADDR_WIDTH, 32: address bus width.
- NUM_REGS, 8: number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0000_1000: byte address of register 0; aligned to NUM_REGS*4.
- REG_ID, 32'h5A5A_0001: constant returned by register NUM_REGS-1.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- ctrl_o  out  AXI_DATA_WIDTH  live value of register 0.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All registers 0 except the ID register.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, ctrl_o=0.
  - Reset asserted mid-transaction aborts it; no response is produced after release.
- Response codes: OKAY=00, SLVERR=10, DECERR=11. EXOKAY is never generated.
- Address decode:
  - offset = addr - BASE_ADDR.
  - In range when addr >= BASE_ADDR and offset < NUM_REGS*4.
  - index = offset[log2(NUM_REGS)+1:2]; addr[1:0] is ignored.
  - Out of range gives DECERR.
- Write FSM states: WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP.
  - WR_IDLE: awready=1, wready=1.
  - AW and W handshaking in the same cycle: perform the write, go to WR_RESP.
  - AW only: latch the address, drop awready, go to WR_WAIT_W.
  - W only: latch data and strobe, drop wready, go to WR_WAIT_AW.
  - WR_WAIT_W / WR_WAIT_AW: on the missing handshake, perform the write and go to WR_RESP.
  - WR_RESP: bvalid=1, awready=0, wready=0. bvalid and bresp are held stable until bready. On bvalid&&bready, return to WR_IDLE with awready=1 and wready=1 in the next cycle.
  - Write commit: on the clock edge that completes the second handshake, byte lane i updates only if wstrb[i]=1.
  - Write to the ID register: no state change, bresp=SLVERR.
  - Out-of-range write: no state change, bresp=DECERR.
  - wstrb=0 to a valid register: no change, bresp=OKAY.
  - Minimum latency: bvalid is asserted the cycle after the last handshake.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: arready=1. On arvalid&&arready, register rdata/rresp and go to RD_DATA.
  - RD_DATA: rvalid=1, arready=0. rdata and rresp are held stable until rready, then return to RD_IDLE.
  - Read latency: rvalid is asserted 1 cycle after the AR handshake.
  - Out-of-range read: rdata=0, rresp=DECERR.
  - Reading the ID register returns REG_ID with OKAY.
- Read and write channels are independent and may be active in the same cycle.
  - If an AR handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- ctrl_o reflects register 0 from the cycle after its write commit.
- Back-to-back operation:
  - Sustained throughput is one write per 2 cycles with bready tied high.
  - Sustained throughput is one read per 2 cycles with rready tied high.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x1000 with wstrb=F (AW and W together) -> bresp=OKAY one cycle later; ctrl_o=0xDEADBEEF; reading 0x1000 returns 0xDEADBEEF, rresp=OKAY.
- Present W (0xCAFEBABE to 0x1004) 3 cycles before AW, then hold bready low for 5 cycles -> wready low while waiting; bvalid stable for 5 cycles; read of 0x1004 returns 0xCAFEBABE.
- Write 0x12345678 to 0x1008, then 0xFFFFFFFF with wstrb=0101 -> read of 0x1008 returns 0x12FF56FF.
- Write 0x9ABCDEF0 to 0x2000 -> bresp=DECERR with no register changed; read of 0x2000 -> rdata=0, rresp=DECERR.
- Write 0x5555AAAA to 0x101C -> bresp=SLVERR; read of 0x101C returns 0x5A5A0001 with OKAY.
- Issue AR to 0x1000 on the same edge as a write commit of 0x11111111 to 0x1000 (prior value 0xDEADBEEF) -> read returns 0xDEADBEEF; a second read returns 0x11111111. Then assert aresetn low during WR_RESP -> bvalid drops immediately and all registers clear.
